// File: rtl/vbus_rr_arbiter.sv
// Four-requester round-robin arbiter for a shared valid/ready bus with burst limiting.
// Define VBUS_ARB_TIMEOUT_EN to enable forced release of a stalled grant after TIMEOUT idle cycles.
module vbus_rr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              req_i,
  input  logic [3:0]              valid_i,
  input  logic [3:0]              last_i,
  input  logic [4*DATA_WIDTH-1:0] data_i,
  output logic [3:0]              ready_o,
  output logic [DATA_WIDTH-1:0]   data_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [3:0]              grant_o,
  output logic                    busy_o,
  output logic                    timeout_o
);

  typedef enum logic {IDLE, GRANT} state_e;

  localparam logic [7:0] BurstLast = 8'(MAX_BURST - 1);

  state_e     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] grantIdx_q, grantIdx_d;
  logic [3:0] grant_q, grant_d;
  logic [7:0] beatCnt_q, beatCnt_d;

  logic       pickValid;
  logic [1:0] pickIdx;
  logic [1:0] cand;
  logic       beat;
  logic       lastBeat;
  logic       burstDone;
  logic       abandon;
  logic       stallHit;
  logic       releaseGrant;

  // Scan from the highest offset down so the requester closest to ptr wins.
  always_comb begin
    pickValid = 1'b0;
    pickIdx   = ptr_q;
    cand      = ptr_q;
    for (int i = 3; i >= 0; i--) begin
      cand = ptr_q + 2'(i);
      if (req_i[cand]) begin
        pickValid = 1'b1;
        pickIdx   = cand;
      end
    end
  end

  assign beat      = (state_q == GRANT) & valid_i[grantIdx_q] & ready_i;
  assign lastBeat  = beat & last_i[grantIdx_q];
  assign burstDone = beat & (beatCnt_q == BurstLast);
  assign abandon   = (state_q == GRANT) & ~req_i[grantIdx_q] & ~valid_i[grantIdx_q];

  assign releaseGrant = (state_q == GRANT) & (lastBeat | burstDone | abandon | stallHit);

`ifdef VBUS_ARB_TIMEOUT_EN
  localparam logic [7:0] StallLast = 8'(TIMEOUT - 1);

  logic [7:0] stallCnt_q, stallCnt_d;
  logic       timeout_q;

  assign stallHit = (state_q == GRANT) & ~beat & (stallCnt_q == StallLast);

  always_comb begin
    stallCnt_d = 8'd0;
    if (state_q == GRANT && !beat && !releaseGrant) begin
      stallCnt_d = stallCnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stallCnt_q <= 8'd0;
      timeout_q  <= 1'b0;
    end else begin
      stallCnt_q <= stallCnt_d;
      timeout_q  <= stallHit;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign stallHit  = 1'b0;
  assign timeout_o = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grantIdx_d = grantIdx_q;
    grant_d    = grant_q;
    beatCnt_d  = beatCnt_q;
    if (state_q == IDLE) begin
      beatCnt_d = 8'd0;
      if (pickValid) begin
        state_d    = GRANT;
        grantIdx_d = pickIdx;
        grant_d    = 4'b0001 << pickIdx;
      end
    end else begin
      if (beat) begin
        beatCnt_d = beatCnt_q + 8'd1;
      end
      if (releaseGrant) begin
        state_d   = IDLE;
        grant_d   = 4'b0000;
        ptr_d     = grantIdx_q + 2'd1;
        beatCnt_d = 8'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= 2'd0;
      grantIdx_q <= 2'd0;
      grant_q    <= 4'b0000;
      beatCnt_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grantIdx_q <= grantIdx_d;
      grant_q    <= grant_d;
      beatCnt_q  <= beatCnt_d;
    end
  end

  // The bus is steered straight through from the granted requester; nothing is registered on the data path.
  always_comb begin
    ready_o = 4'b0000;
    data_o  = '0;
    valid_o = 1'b0;
    if (state_q == GRANT) begin
      data_o              = data_i[grantIdx_q*DATA_WIDTH +: DATA_WIDTH];
      valid_o             = valid_i[grantIdx_q];
      ready_o[grantIdx_q] = ready_i;
    end
  end

  assign grant_o = grant_q;
  assign busy_o  = (state_q == GRANT);

endmodule

// File: tb/tb_vbus_rr_arbiter.sv
// Directed self-checking bench for vbus_rr_arbiter with default parameters.
// Covers grant latency, rotation, burst limit, stall handling and reset mid-burst.
module tb_vbus_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  validIn;
  logic [3:0]  lastIn;
  logic [31:0] dataIn;
  logic [3:0]  readyOut;
  logic [7:0]  dataOut;
  logic        validOut;
  logic        readyIn;
  logic [3:0]  grant;
  logic        busy;
  logic        timeoutOut;

  int checks = 0;
  int errors = 0;

  vbus_rr_arbiter #(.DATA_WIDTH(8), .MAX_BURST(4), .TIMEOUT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req),
    .valid_i   (validIn),
    .last_i    (lastIn),
    .data_i    (dataIn),
    .ready_o   (readyOut),
    .data_o    (dataOut),
    .valid_o   (validOut),
    .ready_i   (readyIn),
    .grant_o   (grant),
    .busy_o    (busy),
    .timeout_o (timeoutOut)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge so registered outputs have settled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] v,
                               input logic [3:0] l, input logic rdy);
    req     = r;
    validIn = v;
    lastIn  = l;
    readyIn = rdy;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    dataIn = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    rst    = 1'b1;
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b0);
    step();
    step();
    checkOutput("rst_grant",   32'(grant),      32'h0);
    checkOutput("rst_busy",    32'(busy),       32'h0);
    checkOutput("rst_valid",   32'(validOut),   32'h0);
    checkOutput("rst_ready",   32'(readyOut),   32'h0);
    checkOutput("rst_data",    32'(dataOut),    32'h0);
    checkOutput("rst_timeout", 32'(timeoutOut), 32'h0);
    rst = 1'b0;

    // Single requester, three beats, last on the third.
    applyStimulus(4'b0001, 4'b0000, 4'b0000, 1'b1);
    checkOutput("req0_no_grant_yet", 32'(grant), 32'h0);
    step();
    checkOutput("req0_grant", 32'(grant), 32'h1);
    checkOutput("req0_busy",  32'(busy),  32'h1);
    applyStimulus(4'b0001, 4'b0001, 4'b0000, 1'b1);
    checkOutput("req0_ready", 32'(readyOut), 32'h1);
    checkOutput("req0_valid", 32'(validOut), 32'h1);
    checkOutput("req0_data",  32'(dataOut),  32'hA0);
    step();
    checkOutput("req0_beat1_hold", 32'(grant), 32'h1);
    step();
    checkOutput("req0_beat2_hold", 32'(grant), 32'h1);
    applyStimulus(4'b0001, 4'b0001, 4'b0001, 1'b1);
    checkOutput("req0_beat3_ready", 32'(readyOut), 32'h1);
    step();
    checkOutput("req0_release_grant", 32'(grant), 32'h0);
    checkOutput("req0_release_busy",  32'(busy),  32'h0);

    // Pointer now 1: requester 1 wins over requester 0, then drops its request.
    applyStimulus(4'b0011, 4'b0000, 4'b0000, 1'b1);
    checkOutput("idle_ready", 32'(readyOut), 32'h0);
    checkOutput("idle_valid", 32'(validOut), 32'h0);
    step();
    checkOutput("ptr1_grant", 32'(grant), 32'h2);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b1);
    step();
    checkOutput("abandon_release", 32'(grant), 32'h0);

    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("rst_pulse_grant", 32'(grant), 32'h0);

    // All requesting with last on every beat: 0,1,2,3,0 with a bubble between.
    applyStimulus(4'b1111, 4'b1111, 4'b1111, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step();
      checkOutput($sformatf("rr_grant_%0d", k), 32'(grant), 32'(4'b0001 << (k % 4)));
      checkOutput($sformatf("rr_data_%0d", k), 32'(dataOut), 32'(8'hA0 + 8'(k % 4) * 8'h11));
      step();
      checkOutput($sformatf("rr_bubble_%0d", k), 32'(grant), 32'h0);
      checkOutput($sformatf("rr_bubble_busy_%0d", k), 32'(busy), 32'h0);
    end

    // Requester 2 streams without last; burst limit releases after 4 beats.
    applyStimulus(4'b0100, 4'b0000, 4'b0000, 1'b1);
    step();
    checkOutput("burst_grant2", 32'(grant), 32'h4);
    applyStimulus(4'b0111, 4'b0111, 4'b0011, 1'b1);
    checkOutput("burst_others_ignored", 32'(readyOut), 32'h4);
    checkOutput("burst_data2", 32'(dataOut), 32'hC2);
    for (int b = 1; b <= 3; b++) begin
      step();
      checkOutput($sformatf("burst_hold_%0d", b), 32'(grant), 32'h4);
    end
    step();
    checkOutput("burst_release", 32'(grant), 32'h0);
    step();
    checkOutput("burst_next0", 32'(grant), 32'h1);
    step();
    checkOutput("burst_bubble0", 32'(grant), 32'h0);
    step();
    checkOutput("burst_next1", 32'(grant), 32'h2);
    step();
    checkOutput("burst_bubble1", 32'(grant), 32'h0);
    step();
    checkOutput("burst_regrant2", 32'(grant), 32'h4);

    // Last coincides with the fourth beat: single release, pointer to 3.
    for (int b = 1; b <= 3; b++) begin
      step();
      checkOutput($sformatf("coinc_hold_%0d", b), 32'(grant), 32'h4);
    end
    applyStimulus(4'b0111, 4'b0111, 4'b0111, 1'b1);
    step();
    checkOutput("coinc_release", 32'(grant), 32'h0);
    applyStimulus(4'b1111, 4'b0000, 4'b0000, 1'b1);
    step();
    checkOutput("coinc_ptr3", 32'(grant), 32'h8);

    // Requester 3 stalls with request held and no valid.
    applyStimulus(4'b1000, 4'b0000, 4'b0000, 1'b1);
`ifdef VBUS_ARB_TIMEOUT_EN
    for (int s = 1; s <= 15; s++) begin
      step();
      checkOutput($sformatf("stall_hold_%0d", s), 32'(grant), 32'h8);
      checkOutput($sformatf("stall_no_to_%0d", s), 32'(timeoutOut), 32'h0);
    end
    step();
    checkOutput("timeout_release", 32'(grant), 32'h0);
    checkOutput("timeout_pulse", 32'(timeoutOut), 32'h1);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b1);
    step();
    checkOutput("timeout_pulse_end", 32'(timeoutOut), 32'h0);
    checkOutput("timeout_idle", 32'(grant), 32'h0);
`else
    for (int s = 1; s <= 120; s++) begin
      step();
      checkOutput($sformatf("stall_hold_%0d", s), 32'(grant), 32'h8);
      checkOutput($sformatf("stall_no_to_%0d", s), 32'(timeoutOut), 32'h0);
    end
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b1);
    step();
    checkOutput("stall_abandon", 32'(grant), 32'h0);
`endif

    // Move the pointer to 2, then reset in the middle of a burst on requester 1.
    applyStimulus(4'b0010, 4'b0010, 4'b0010, 1'b1);
    step();
    checkOutput("pre_grant1", 32'(grant), 32'h2);
    step();
    checkOutput("pre_release1", 32'(grant), 32'h0);
    applyStimulus(4'b0010, 4'b0010, 4'b0000, 1'b1);
    step();
    checkOutput("mid_grant1", 32'(grant), 32'h2);
    step();
    checkOutput("mid_beat1_hold", 32'(grant), 32'h2);
    rst = 1'b1;
    step();
    checkOutput("mid_rst_grant", 32'(grant),    32'h0);
    checkOutput("mid_rst_ready", 32'(readyOut), 32'h0);
    checkOutput("mid_rst_busy",  32'(busy),     32'h0);
    checkOutput("mid_rst_valid", 32'(validOut), 32'h0);
    rst = 1'b0;
    applyStimulus(4'b1111, 4'b0000, 4'b0000, 1'b1);
    step();
    checkOutput("post_rst_grant0", 32'(grant), 32'h1);

    applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b0);
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vbus_rr_arbiter.md
VBUS_RR_ARBITER -- requirements
Module: vbus_rr_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8: width of each requester data bus and of the shared output bus.
REQ-002 The block SHALL have parameter MAX_BURST, default 4: maximum accepted beats per grant, legal range 1..255.
REQ-003 The block SHALL have parameter TIMEOUT, default 16: stall cycles before a forced release, legal range 1..255.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, all state on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port req_i, input, 4 bits: per-requester access request.
REQ-007 The block SHALL have port valid_i, input, 4 bits: per-requester beat valid.
REQ-008 The block SHALL have port last_i, input, 4 bits: per-requester last-beat marker.
REQ-009 The block SHALL have port data_i, input, 4*DATA_WIDTH bits: requester n occupies bits [n*DATA_WIDTH +: DATA_WIDTH].
REQ-010 The block SHALL have port ready_o, output, 4 bits: per-requester beat accept.
REQ-011 The block SHALL have port data_o, output, DATA_WIDTH bits: shared bus data.
REQ-012 The block SHALL have port valid_o, output, 1 bit: shared bus valid.
REQ-013 The block SHALL have port ready_i, input, 1 bit: shared bus ready from the sink.
REQ-014 The block SHALL have port grant_o, output, 4 bits: one-hot registered grant.
REQ-015 The block SHALL have port busy_o, output, 1 bit: high in state GRANT.
REQ-016 The block SHALL have port timeout_o, output, 1 bit: forced-release pulse.

Function
REQ-017 The block SHALL implement two states, IDLE and GRANT, plus a 2-bit round-robin pointer ptr.
REQ-018 In IDLE with req_i nonzero, the block SHALL select the first requester at or after ptr (cyclic order ptr, ptr+1, ...), register it into grant_o, and enter GRANT on the next edge; grant_o SHALL rise exactly 1 cycle after req_i is sampled.
REQ-019 In IDLE, grant_o, ready_o and valid_o SHALL be 0, and data_o SHALL be 0.
REQ-020 In GRANT with granted index g, the block SHALL drive data_o = data_i[g], valid_o = valid_i[g] and ready_o[g] = ready_i combinationally; all other ready_o bits SHALL be 0.
REQ-021 A beat SHALL be defined as valid_i[g] AND ready_i; a beat counter, cleared on entry to GRANT, SHALL increment on each beat.
REQ-022 The block SHALL release the grant on the edge where any of the following holds: a beat with last_i[g]=1; the beat that makes the count equal MAX_BURST; or req_i[g]=0 while valid_i[g]=0.
REQ-023 On release, the block SHALL clear grant_o, set ptr to (g+1) mod 4 and return to IDLE; this gives exactly one bubble cycle between grants.
REQ-024 The block SHALL ignore requests from non-granted requesters during GRANT; they SHALL be considered only in the next IDLE cycle.
REQ-025 When last_i[g] coincides with the MAX_BURST beat, the block SHALL perform a single release, with no double pointer advance.
REQ-026 With MAX_BURST=1, every accepted beat SHALL release the grant.

Reset
REQ-027 While rst=1 at a clock edge, the block SHALL set state IDLE, ptr=0, beat and stall counters to 0, grant_o=0 and timeout_o=0; busy_o, valid_o, ready_o and data_o SHALL then read 0.
REQ-028 Reset asserted during GRANT SHALL drop grant_o at that edge and discard the partial burst, with no release pointer advance.

Configuration
REQ-029 With macro VBUS_ARB_TIMEOUT_EN defined, a stall counter SHALL count consecutive GRANT cycles with no beat, clear on any beat, and force a release (per REQ-023) when it reaches TIMEOUT; timeout_o SHALL be 1 for exactly the release cycle.
REQ-030 With VBUS_ARB_TIMEOUT_EN undefined, the stall counter SHALL not exist, timeout_o SHALL be constant 0, and a stalled grant SHALL persist indefinitely.

Verification
REQ-031 Bench: req_i=4'b0001, 3 beats with last on the third, ready_i=1 -> grant_o=0001 one cycle after req; 3 beats accepted; grant_o=0 after the last beat; ptr=1.
REQ-032 Bench: req_i=4'b1111 held, last_i=1 on every beat -> grant order 0,1,2,3,0, with one IDLE cycle between grants.
REQ-033 Bench: requester 2 streams 10 beats with no last, MAX_BURST=4 -> release after the 4th beat; regrant to 2 only after the other active requesters are served.
REQ-034 Bench: VBUS_ARB_TIMEOUT_EN defined, TIMEOUT=16, granted requester holds valid_i=0 and req_i=1 -> forced release after 16 stall cycles with a one-cycle timeout_o pulse; macro undefined -> the grant is held for more than 100 cycles.
REQ-035 Bench: rst=1 asserted mid-burst on requester 1 -> at that edge grant_o=0, ready_o=0 and busy_o=0; after rst=0 with all requests high, requester 0 is granted first.
